alu_seq: RTL and testbench

Parametrised, handshaked successor to the KGP_RISC combinational ALU. It executes one operation per transaction: add, negate, and, xor, the three shifts, and a lowest-differing-bit "diff". The result and the carry/zero/sign flags are registered. Operands enter through a valid/ready handshake and results leave through a valid/ready handshake. Shifts run iteratively, one bit per cycle, unless the barrel shifter is compiled in. The block sits between the register-read stage and writeback in the multi-cycle datapath.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_shift_iter.sv | 67 ++++++
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 tb/tb_alu_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the alu_seq block.
//   - op encodings (ALU_ADD .. ALU_DIFF)
//   - second-operand select encodings (SRC_B, SRC_SHAMT, SRC_OFFSET)
//   - FSM state encoding
// Build option: ALU_SEQ_BARREL_SHIFT_EN removes the SHIFT state.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_NEG  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_SHL  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_SRA  = 3'b110;
  localparam logic [2:0] ALU_DIFF = 3'b111;

  // 2'b11 also selects b.
  localparam logic [1:0] SRC_B      = 2'b00;
  localparam logic [1:0] SRC_SHAMT  = 2'b01;
  localparam logic [1:0] SRC_OFFSET = 2'b10;

`ifdef ALU_SEQ_BARREL_SHIFT_EN
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StDone = 2'b10
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;
`endif

  function automatic logic is_shift(input logic [2:0] op);
    return (op == ALU_SHL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// alu_shift_iter: iterative shifter, one bit per cycle.
//   clk, rst   : clock, synchronous active-high reset
//   start      : load data_in/amount/op into the working state
//   op         : ALU_SHL, ALU_SRL or ALU_SRA (captured on start)
//   data_in    : value to shift
//   amount     : shift count (captured on start)
//   data_next  : working value after the shift happening this cycle
//   last       : this cycle performs the final shift step
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   amount,
  output logic [WIDTH-1:0] data_next,
  output logic             last
);

  logic [WIDTH-1:0] work_q, work_d, shifted;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;

  always_comb begin
    case (op_q)
      ALU_SHL: shifted = {work_q[WIDTH-2:0], 1'b0};
      ALU_SRL: shifted = {1'b0, work_q[WIDTH-1:1]};
      ALU_SRA: shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: shifted = work_q;
    endcase
  end

  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    if (start) begin
      work_d = data_in;
      cnt_d  = amount;
      op_d   = op;
    end else if (cnt_q != '0) begin
      work_d = shifted;
      cnt_d  = cnt_q - SHW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      cnt_q  <= '0;
      op_q   <= ALU_ADD;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
    end
  end

  assign data_next = shifted;
  assign last      = (cnt_q == SHW'(1));

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result and carry/zero/sign flags.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : request handshake (op, src, a, b, shamt, offset)
//   op                   : ADD NEG AND XOR SHL SRL SRA DIFF
//   src                  : second-operand select (b, shamt, offset, b)
//   out_valid / out_ready: result handshake (result, carry, zero, sign)
// Build option: define ALU_SEQ_BARREL_SHIFT_EN for single-cycle barrel shifts;
// otherwise shifts run one bit per cycle in alu_shift_iter.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [1:0]       src,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] shamt,
  input  logic [WIDTH-1:0] offset,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             sign
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d, zero_q, zero_d, sign_q, sign_d;
  logic             out_valid_q, out_valid_d;
  logic             load;

  logic [WIDTH-1:0] m;
  logic [SHW-1:0]   k;
  logic [WIDTH-1:0] diff_x, diff_res;
  logic [WIDTH-1:0] op_res;
  logic             op_carry;

  always_comb begin
    case (src)
      SRC_SHAMT:  m = shamt;
      SRC_OFFSET: m = offset;
      default:    m = b;
    endcase
  end

  assign k      = m[SHW-1:0];
  assign diff_x = a ^ m;

  // Scan downwards so the lowest set bit wins.
  always_comb begin
    diff_res = WIDTH'(WIDTH);
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (diff_x[i]) diff_res = WIDTH'(i);
    end
  end

  always_comb begin
    op_res   = '0;
    op_carry = 1'b0;
    case (op)
      ALU_ADD: {op_carry, op_res} = {1'b0, a} + {1'b0, m};
      ALU_NEG: op_res = ~m + WIDTH'(1);
      ALU_AND: op_res = a & m;
      ALU_XOR: op_res = a ^ m;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
      ALU_SHL: op_res = a << k;
      ALU_SRL: op_res = a >> k;
      ALU_SRA: op_res = WIDTH'($signed(a) >>> k);
`else
      // Only reached here with k == 0; larger counts go through the iterative shifter.
      ALU_SHL, ALU_SRL, ALU_SRA: op_res = a;
`endif
      default: op_res = diff_res;
    endcase
  end

`ifndef ALU_SEQ_BARREL_SHIFT_EN
  logic             sh_start, sh_last;
  logic [WIDTH-1:0] sh_next;

  alu_shift_iter #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_shift_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (sh_start),
    .op       (op),
    .data_in  (a),
    .amount   (k),
    .data_next(sh_next),
    .last     (sh_last)
  );
`endif

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    load        = 1'b0;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
    sh_start    = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
`ifndef ALU_SEQ_BARREL_SHIFT_EN
          if (is_shift(op) && (k != '0)) begin
            sh_start = 1'b1;
            state_d  = StShift;
          end else
`endif
          begin
            result_d    = op_res;
            carry_d     = op_carry;
            load        = 1'b1;
            out_valid_d = 1'b1;
            state_d     = StDone;
          end
        end
      end
`ifndef ALU_SEQ_BARREL_SHIFT_EN
      StShift: begin
        // Capture the final step's output directly so DONE follows the last shift.
        if (sh_last) begin
          result_d    = sh_next;
          carry_d     = 1'b0;
          load        = 1'b1;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
`endif
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
    zero_d = load ? (result_d == '0) : zero_q;
    sign_d = load ? result_d[WIDTH-1] : sign_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign sign      = sign_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a
// behavioural model (plain arithmetic on the operation definitions).
module tb_alu_seq;

  localparam int unsigned W = 32;
  typedef logic [W:0] val_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = '0;
  logic [1:0]   src = '0;
  logic [W-1:0] a = '0, b = '0, shamt = '0, offset = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry, zero, sign;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .src      (src),
    .a        (a),
    .b        (b),
    .shamt    (shamt),
    .offset   (offset),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
    .sign     (sign)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input val_t obs, input val_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pick_m(input logic [1:0] s, input logic [W-1:0] bv,
                                          input logic [W-1:0] sv, input logic [W-1:0] ov);
    if (s == 2'd1) return sv;
    if (s == 2'd2) return ov;
    return bv;
  endfunction

  // Reference behaviour from the operation definitions.
  task automatic model(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] mv,
                       output logic [W-1:0] r, output logic c, output int lat);
    logic [W:0]   s;
    logic [W-1:0] x;
    int           sh;
    sh  = int'(mv % W);
    c   = 1'b0;
    lat = 1;
    case (o)
      3'd0: begin s = {1'b0, av} + {1'b0, mv}; r = s[W-1:0]; c = s[W]; end
      3'd1: r = '0 - mv;
      3'd2: r = av & mv;
      3'd3: r = av ^ mv;
      3'd4: r = av << sh;
      3'd5: r = av >> sh;
      3'd6: r = $unsigned($signed(av) >>> sh);
      default: begin
        if (av == mv) r = W;
        else begin
          x = av ^ mv;
          r = 0;
          while (x[0] == 1'b0) begin x = x >> 1; r = r + 1; end
        end
      end
    endcase
`ifndef ALU_SEQ_BARREL_SHIFT_EN
    if (o >= 3'd4 && o <= 3'd6) lat = sh + 1;
`endif
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [1:0] s,
                        input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] sv,
                        input logic [W-1:0] ov, input int hold);
    logic [W-1:0] er;
    logic         ec;
    int           elat, lat;
    model(o, av, pick_m(s, bv, sv, ov), er, ec, elat);
    @(negedge clk);
    check({tag, "_in_ready_idle"}, val_t'(in_ready), val_t'(1));
    op = o; src = s; a = av; b = bv; shamt = sv; offset = ov;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble inputs: the transaction in flight must not see them.
    op = 3'($urandom); src = 2'($urandom);
    a = $urandom; b = $urandom; shamt = $urandom; offset = $urandom;
    lat = 1;
    while (!out_valid && lat < 2 * int'(W)) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, val_t'(lat), val_t'(elat));
    check({tag, "_result"}, val_t'(result), val_t'(er));
    check({tag, "_carry"}, val_t'(carry), val_t'(ec));
    check({tag, "_zero"}, val_t'(zero), val_t'(er == '0));
    check({tag, "_sign"}, val_t'(sign), val_t'(er[W-1]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, val_t'(out_valid), val_t'(1));
      check({tag, "_hold_in_ready"}, val_t'(in_ready), val_t'(0));
      check({tag, "_hold_result"}, val_t'({carry, zero, sign, result[W-4:0]}),
            val_t'({ec, er == '0, er[W-1], er[W-4:0]}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_post_in_ready"}, val_t'(in_ready), val_t'(1));
    check({tag, "_post_out_valid"}, val_t'(out_valid), val_t'(0));
  endtask

  logic [W-1:0] exp_q[$];
  logic [W-1:0] ra, rb, rs;
  int           n_res, n_acc;

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", val_t'(in_ready), val_t'(1));
    check("rst_out_valid", val_t'(out_valid), val_t'(0));
    check("rst_result", val_t'(result), val_t'(0));
    check("rst_flags", val_t'({carry, zero, sign}), val_t'(0));

    run_op("add_wrap", 3'd0, 2'b00, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 0);
    run_op("sra4", 3'd6, 2'b01, 32'h8000_0000, 32'h0, 32'h4, 32'h0, 0);
    run_op("diff5", 3'd7, 2'b00, 32'h10, 32'h30, 32'h0, 32'h0, 0);
    run_op("diff_eq", 3'd7, 2'b00, 32'h1234, 32'h1234, 32'h0, 32'h0, 0);
    run_op("neg_hold", 3'd1, 2'b10, 32'h0, 32'h0, 32'h0, 32'h5, 10);
    run_op("src11_b", 3'd3, 2'b11, 32'hA5A5_0000, 32'h0000_5A5A, 32'h0, 32'h0, 0);
    run_op("shl_k0", 3'd4, 2'b01, 32'h1357_9BDF, 32'h0, 32'h20, 32'h0, 0);

    // Reset in the middle of a long shift.
    @(negedge clk);
    op = 3'd4; src = 2'b01; a = 32'h0000_0F0F; shamt = 32'd20; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_busy_valid", val_t'(out_valid), val_t'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_in_ready", val_t'(in_ready), val_t'(1));
    check("midrst_out_valid", val_t'(out_valid), val_t'(0));
    check("midrst_result", val_t'(result), val_t'(0));
    check("midrst_flags", val_t'({carry, zero, sign}), val_t'(0));
    repeat (25) begin
      @(posedge clk);
      #1;
      check("midrst_no_pulse", val_t'(out_valid), val_t'(0));
    end
    run_op("and_after_rst", 3'd2, 2'b00, 32'hF0F0, 32'h0FF0, 32'h0, 32'h0, 0);

    // Back-to-back XOR with in_valid held high.
    n_res = 0;
    n_acc = 0;
    out_ready = 1'b1;
    op = 3'd3; src = 2'b00;
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (in_ready) begin
        a = $urandom; b = $urandom;
        exp_q.push_back(a ^ b);
        n_acc++;
      end
      @(posedge clk);
      #1;
      if (out_valid) begin
        n_res++;
        if (exp_q.size() > 0) check("b2b_xor", val_t'(result), val_t'(exp_q.pop_front()));
        else check("b2b_xor_spurious", val_t'(1), val_t'(0));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_accepts", val_t'(n_acc), val_t'(6));
    check("b2b_results", val_t'(n_res), val_t'(6));
    @(posedge clk);
    #1;

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rs = $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra;
      run_op("rand", 3'($urandom), 2'($urandom), ra, rb, rs, rb ^ 32'h0F0F_F0F0,
             int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
